// File: rtl/data_rx_packer_pkg.sv
// Shared widths and state encoding for the UART byte packer and its
// transmit-side counterpart.
package data_rx_packer_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } rx_state_t;

    function automatic logic [WORD_W-1:0] shift_in(
        input logic [WORD_W-1:0] word,
        input logic [BYTE_W-1:0] data
    );
        return {word[WORD_W-BYTE_W-1:0], data};
    endfunction

endpackage

// File: rtl/data_rx_packer_if.sv
// Byte-in / word-out bus between UART RX core, packer and receive FIFO.
interface data_rx_packer_if;
    import data_rx_packer_pkg::*;

    logic [BYTE_W-1:0] RxData;
    logic              RxDataValid;
    logic              FIFOFull;
    logic [WORD_W-1:0] FIFOData;
    logic              FIFOWriteEnable;

    modport master (
        output RxData,
        output RxDataValid,
        output FIFOFull,
        input  FIFOData,
        input  FIFOWriteEnable
    );

    modport slave (
        input  RxData,
        input  RxDataValid,
        input  FIFOFull,
        output FIFOData,
        output FIFOWriteEnable
    );

endinterface

// File: rtl/data_rx_packer_rx_timeout_timer.sv
// Inter-byte idle timer; Expired flags the cycle the idle budget runs out.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Enable,
    input  logic Restart,
    output logic Expired
);

    logic [TIMEOUT_W-1:0] count;

    // A restart in the terminal cycle wins over expiry.
    assign Expired = Enable && !Restart &&
                     (count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset || !Enable || Restart || Expired)
            count <= '0;
        else
            count <= count + TIMEOUT_W'(1);
    end

endmodule

// File: rtl/data_rx_packer.sv
// Packs UART bytes MSB-first into 32-bit words for the command FIFO,
// with inter-byte timeout resync and a sticky overrun flag.
module data_rx_packer
    import data_rx_packer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES)
) (
    input  logic              Clk,
    input  logic              Reset,
    data_rx_packer_if.slave   bus,
    input  logic              ClearErrors,
    output logic              Overrun,
    output logic              TimeoutPulse,
    output logic [BCNT_W-1:0] ByteCount
);

    rx_state_t         state, state_n;
    logic [WORD_W-1:0] word, word_n;
    logic [BCNT_W-1:0] cnt, cnt_n;
    logic              ovr, ovr_n;
    logic              tp, tp_n;
    logic              write;
    logic              expired;
    logic              tmr_en;

    assign tmr_en = (state == COLLECT) && (cnt != '0);

    rx_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .Enable  (tmr_en),
        .Restart (bus.RxDataValid),
        .Expired (expired)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= COLLECT;
            word  <= '0;
            cnt   <= '0;
            ovr   <= 1'b0;
            tp    <= 1'b0;
        end else begin
            state <= state_n;
            word  <= word_n;
            cnt   <= cnt_n;
            ovr   <= ovr_n;
            tp    <= tp_n;
        end
    end

    always_comb begin
        state_n = state;
        word_n  = word;
        cnt_n   = cnt;
        ovr_n   = ovr && !ClearErrors;
        tp_n    = 1'b0;
        write   = 1'b0;
        unique case (state)
            COLLECT: begin
                if (bus.RxDataValid) begin
                    word_n = shift_in(word, bus.RxData);
                    if (cnt == BCNT_W'(BYTES_PER_WORD - 1)) begin
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else begin
                        cnt_n = cnt + BCNT_W'(1);
                    end
                end else if (expired) begin
                    cnt_n = '0;
                    tp_n  = 1'b1;
                end
            end
            HOLD: begin
                write = !bus.FIFOFull;
                if (!bus.FIFOFull) begin
                    state_n = COLLECT;
                    // A byte landing in the write slot opens the next word.
                    if (bus.RxDataValid) begin
                        word_n = shift_in(word, bus.RxData);
                        cnt_n  = BCNT_W'(1);
                    end
                end else if (bus.RxDataValid) begin
                    ovr_n = 1'b1;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // A held word is abandoned, not written, when reset hits.
    assign bus.FIFOWriteEnable = write && !Reset;
    assign bus.FIFOData        = word;
    assign Overrun             = ovr;
    assign TimeoutPulse        = tp;
    assign ByteCount           = cnt;

endmodule

// File: tb/tb_data_rx_packer.sv
// Scoreboard bench for data_rx_packer: directed scenarios plus random traffic.
module tb_data_rx_packer;
    import data_rx_packer_pkg::*;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       ovr;
    logic       tp;
    logic [1:0] bc;

    always #5 clk = ~clk;

    data_rx_packer_if bus();

    data_rx_packer #(.TIMEOUT_CYCLES(T)) dut (
        .Clk          (clk),
        .Reset        (rst),
        .bus          (bus.slave),
        .ClearErrors  (clr),
        .Overrun      (ovr),
        .TimeoutPulse (tp),
        .ByteCount    (bc)
    );

    typedef struct packed {
        logic       chk;
        logic       we;
        logic       ovr;
        logic       tp;
        logic [1:0] bc;
    } exp_t;

    exp_t        sq[$];
    logic [31:0] wq[$];

    int          vectors = 0;
    int          errs    = 0;
    int          nwrites = 0;
    int          tp_seen = 0;
    logic [31:0] last_word = '0;

    // Reference model: a list of pending bytes, an optional held word.
    logic [7:0]  bq[$];
    bit          held;
    logic [31:0] hw;
    bit          m_ovr;
    bit          m_tp;
    int          idle;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            check("write_enable", 32'(bus.FIFOWriteEnable), 32'(e.we));
            if (e.chk) begin
                check("overrun", 32'(ovr), 32'(e.ovr));
                check("timeout_pulse", 32'(tp), 32'(e.tp));
                check("byte_count", 32'(bc), 32'(e.bc));
            end
        end
        if (tp === 1'b1) tp_seen++;
        if (bus.FIFOWriteEnable === 1'b1) begin
            nwrites++;
            last_word = bus.FIFOData;
            if (wq.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_write: got %h expected none", bus.FIFOData);
            end else begin
                check("fifo_data", bus.FIFOData, wq.pop_front());
            end
        end
    end

    task automatic model_clear();
        bq.delete();
        held  = 0;
        hw    = '0;
        m_ovr = 0;
        m_tp  = 0;
        idle  = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d,
                        input bit full, input bit c);
        exp_t e;
        bit   set;
        bit   ntp;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.RxDataValid = v;
        bus.RxData      = v ? d : 8'($urandom);
        bus.FIFOFull    = full;
        clr             = c;
        e.chk = 1'b1;
        e.we  = held && !full;
        e.ovr = m_ovr;
        e.tp  = m_tp;
        e.bc  = 2'(bq.size());
        sq.push_back(e);
        set = 0;
        ntp = 0;
        if (held) begin
            if (!full) begin
                wq.push_back(hw);
                held = 0;
                if (v) begin
                    bq.push_back(d);
                    idle = 0;
                end
            end else if (v) begin
                set = 1;
            end
        end else if (v) begin
            bq.push_back(d);
            idle = 0;
            if (bq.size() == BYTES_PER_WORD) begin
                hw   = {bq[0], bq[1], bq[2], bq[3]};
                bq.delete();
                held = 1;
            end
        end else if (bq.size() != 0) begin
            idle++;
            if (idle == T) begin
                bq.delete();
                idle = 0;
                ntp  = 1;
            end
        end
        m_ovr = set || (m_ovr && !c);
        m_tp  = ntp;
    endtask

    task automatic do_reset(input int n, input bit full);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst             = 1'b1;
            bus.RxDataValid = 1'b0;
            bus.FIFOFull    = full;
            clr             = 1'b0;
            e     = '0;
            sq.push_back(e);
        end
        model_clear();
    endtask

    task automatic send_word(input logic [31:0] w, input bit full);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            step(1, t[31:24], full, 0);
            t = t << 8;
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
    endtask

    int          n0;
    int          t0;
    logic [31:0] w;

    initial begin
        rst             = 1'b1;
        clr             = 1'b0;
        bus.RxData      = '0;
        bus.RxDataValid = 1'b0;
        bus.FIFOFull    = 1'b0;
        model_clear();
        do_reset(2, 0);
        check("reset_data", bus.FIFOData, 32'h0);
        check("reset_bc", 32'(bc), 32'h0);

        n0 = nwrites;
        w  = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            step(1, w[31:24], 0, 0);
            w = w << 8;
            if (i < 3) idle_n(9);
        end
        idle_n(3);
        check("spaced_count", 32'(nwrites - n0), 32'd1);
        check("spaced_word", last_word, 32'hDEADBEEF);

        n0 = nwrites;
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
        idle_n(3);
        check("b2b_count", 32'(nwrites - n0), 32'd2);
        check("b2b_word", last_word, 32'h05060708);

        n0 = nwrites;
        send_word(32'h11223344, 1);
        step(0, 8'h00, 1, 0);
        step(1, 8'hAA, 1, 0);
        step(0, 8'h00, 1, 0);
        check("ovr_set", 32'(ovr), 32'd1);
        check("held_no_write", 32'(nwrites - n0), 32'd0);
        step(0, 8'h00, 0, 0);
        send_word(32'h55667788, 0);
        idle_n(2);
        check("held_word_count", 32'(nwrites - n0), 32'd2);
        check("fresh_word", last_word, 32'h55667788);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0);
        check("ovr_clear", 32'(ovr), 32'd0);

        t0 = tp_seen;
        step(1, 8'h12, 0, 0);
        step(1, 8'h34, 0, 0);
        idle_n(T + 3);
        check("timeout_pulses", 32'(tp_seen - t0), 32'd1);
        check("timeout_bc", 32'(bc), 32'd0);
        send_word(32'hCAFEF00D, 0);
        idle_n(2);
        check("after_timeout", last_word, 32'hCAFEF00D);

        t0 = tp_seen;
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        idle_n(T - 1);
        step(1, 8'h03, 0, 0);
        step(0, 8'h00, 0, 0);
        check("expiry_no_pulse", 32'(tp_seen - t0), 32'd0);
        check("expiry_bc", 32'(bc), 32'd3);
        step(1, 8'h04, 0, 0);
        idle_n(2);
        check("expiry_word", last_word, 32'h01020304);

        n0 = nwrites;
        step(1, 8'h99, 0, 0);
        step(1, 8'h98, 0, 0);
        step(1, 8'h97, 0, 0);
        do_reset(1, 0);
        send_word(32'hA1B2C3D4, 0);
        idle_n(2);
        check("reset_mid_count", 32'(nwrites - n0), 32'd1);
        check("reset_mid_word", last_word, 32'hA1B2C3D4);

        n0 = nwrites;
        send_word(32'h0BADF00D, 1);
        do_reset(1, 0);
        idle_n(3);
        check("reset_hold_nowrite", 32'(nwrites - n0), 32'd0);

        send_word(32'h13579BDF, 1);
        step(0, 8'h00, 1, 1);
        step(1, 8'h55, 1, 1);
        step(0, 8'h00, 1, 0);
        check("ovr_set_wins", 32'(ovr), 32'd1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0);
        check("ovr_clear_alone", 32'(ovr), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int pv;
            pv = ((i / 200) % 3 == 2) ? 5 : 55;
            step(($urandom_range(99) < pv), 8'($urandom),
                 ($urandom_range(99) < 30), ($urandom_range(99) < 4));
        end
        idle_n(T + 4);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
